fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the fetch unit and its decoder consumer
package fetch_unit_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic {FETCH, DRAIN} state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of {pc, instr} with synchronous flush
// Ports: clk, rst_n (async low); flush_i/push_i/pop_i controls; entry_i write data;
//        head_o oldest entry (undefined when empty); count_o occupancy.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  fetch_entry_t  entry_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  fetch_entry_t  mem_q [DEPTH];
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= pop_i ? nxt(rd_q) : rd_q;
      wr_q  <= push_i ? nxt(wr_q) : wr_q;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  // At full occupancy a push lands in the slot being popped the same cycle.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= entry_i;
  end
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with in-order memory requests, buffering and redirect drain
// Ports: clk, rst_n (async low); imem_req_valid/ready/addr request channel;
//        imem_rsp_valid/data response channel; instr_valid/ready/instr/instr_pc/
//        instr_pc_plus4 to decoder; redirect_valid/target from branch resolution;
//        misalign pulse for an unaligned redirect target.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        misalign
);
  localparam int CW = $clog2(DEPTH + 1);
  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d, rsp_pc, tgt;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt;
  logic          accept, push, pop;
  fetch_entry_t  head, rsp_entry;
  assign tgt    = {redirect_target[31:2], 2'b00};
  // Responses return in order, so the oldest live request sits out_q words behind fetch_pc.
  assign rsp_pc = pc_q - 32'({out_q, 2'b00});
  assign rsp_entry = '{pc: rsp_pc, instr: imem_rsp_data};
  // Counting buffered entries plus in-flight requests keeps the FIFO from ever overflowing.
  assign imem_req_valid = rst_n && state_q == FETCH && !redirect_valid &&
                          ({1'b0, out_q} + {1'b0, cnt}) < (CW + 1)'(DEPTH);
  assign imem_addr      = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = state_q == FETCH && imem_rsp_valid && !redirect_valid;
  assign pop            = instr_valid && instr_ready && !redirect_valid;
  assign instr_valid    = cnt != '0;
  assign instr          = instr_valid ? head.instr : '0;
  assign instr_pc       = instr_valid ? head.pc : '0;
  assign instr_pc_plus4 = instr_pc + 32'd4;
  assign misalign       = rst_n && redirect_valid && |redirect_target[1:0];
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    drop_d  = drop_q;
    if (state_q == FETCH) begin
      out_d = out_q + CW'(accept) - CW'(imem_rsp_valid);
      pc_d  = accept ? pc_q + 32'd4 : pc_q;
      if (redirect_valid) begin
        pc_d    = tgt;
        out_d   = '0;
        drop_d  = out_q - CW'(imem_rsp_valid);
        state_d = (drop_d != '0) ? DRAIN : FETCH;
      end
    end else begin
      drop_d  = imem_rsp_valid ? drop_q - 1'b1 : drop_q;
      pc_d    = redirect_valid ? tgt : pc_q;
      state_d = (drop_d == '0) ? FETCH : DRAIN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(redirect_valid),
    .push_i (push),
    .pop_i  (pop),
    .entry_i(rsp_entry),
    .head_o (head),
    .count_o(cnt)
  );
endmodule
